apb_regfile: RTL and testbench

Parametrised APB4 slave register file: the next-generation control/status register bank for our peripheral IPs. It provides NUM_REGS registers of DATA_W bits with byte-lane write strobes, a real read path, per-register read-only (status) mapping, configurable wait states, and PSLVERR signalling. It sits between the APB interconnect and a peripheral core: the core consumes `reg_out` and supplies `status_in`.

---
 rtl/apb_regfile.sv | 187 ++++++++++++++++++
 tb/tb_apb_regfile.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile.sv
// apb_regfile: APB4 slave control/status register bank.
//
// Provides NUM_REGS registers of DATA_W bits. RW registers take byte-strobed
// writes from the bus. RO registers are not stored; they are read from status_in.
// Every access phase has WAIT_CYCLES pready-low cycles and then a single
// registered response cycle.
//
// Ports
//   pclk, preset_n       clock, synchronous active-low reset
//   psel/penable/pwrite  APB control
//   paddr                register word index
//   pwdata/pstrb         write data and byte-lane strobes
//   prdata/pready/pslverr  registered response, non-zero only in RESP
//   reg_out              flattened RW contents (RO slots drive 0)
//   status_in            flattened status values (only RO slots used)

// Per-register slice. A RW slot holds a byte-strobed flop. A RO slot passes status through.
module apb_regfile_reg #(
  parameter int DATA_W = 32,
  parameter bit RO     = 1'b0
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              we,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] status,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] reg_out
);
  if (RO) begin : g_ro
    logic unused_rw;
    assign unused_rw = ^{pclk, preset_n, we, wstrb, wdata};
    assign rd_val    = status;
    assign reg_out   = '0;
  end else begin : g_rw
    logic [DATA_W-1:0] data_q, data_d;
    logic unused_st;
    assign unused_st = ^status;

    always_comb begin
      data_d = data_q;
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (wstrb[b]) data_d[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end

    always_ff @(posedge pclk) begin
      if (!preset_n) data_q <= '0;
      else           data_q <= data_d;
    end

    assign rd_val  = data_q;
    assign reg_out = data_q;
  end
endmodule

module apb_regfile #(
  parameter int                  DATA_W      = 32,
  parameter int                  ADDR_W      = 8,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic [NUM_REGS-1:0][DATA_W-1:0] rd_val;
  logic [NUM_REGS-1:0]             we;
  logic [DATA_W-1:0]               rd_mux;
  logic                            addr_oob, ro_hit, err_c, commit, enter_resp;

  // Address decode is purely combinational on paddr/pwrite.
  assign addr_oob = {1'b0, paddr} >= (ADDR_W+1)'(NUM_REGS);

  always_comb begin
    ro_hit = 1'b0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (paddr == ADDR_W'(i)) begin
        ro_hit = RO_MASK[i];
        rd_mux = rd_val[i];
      end
    end
  end

  assign err_c  = addr_oob | (pwrite & ro_hit);
  // Writes land on the edge leaving RESP; errored writes are dropped.
  assign commit = (state_q == RESP) & psel & penable & pwrite & ~err_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response is captured on the edge entering RESP, so outputs are registered.
  assign enter_resp = (state_d == RESP);

  always_comb begin
    pready_d  = enter_resp;
    pslverr_d = enter_resp & err_c;
    prdata_d  = (enter_resp && !pwrite && !err_c) ? rd_mux : '0;
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign we[i] = commit & (paddr == ADDR_W'(i));
    apb_regfile_reg #(
      .DATA_W (DATA_W),
      .RO     (RO_MASK[i])
    ) u_reg (
      .pclk     (pclk),
      .preset_n (preset_n),
      .we       (we[i]),
      .wstrb    (pstrb),
      .wdata    (pwdata),
      .status   (status_in[i*DATA_W +: DATA_W]),
      .rd_val   (rd_val[i]),
      .reg_out  (reg_out[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_apb_regfile.sv
// Bench for apb_regfile: two instances share one APB bus; sel picks which one
// gets psel. dut0 has no wait states and reg 7 mapped RO; dut3 has 3 wait states.
module tb_apb_regfile;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel, penable, pwrite, sel;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;

  logic [31:0]  prdata0, prdata3;
  logic         pready0, pready3, pslverr0, pslverr3;
  logic [255:0] reg_out0, reg_out3, status0, status3;

  logic [31:0]  prd;
  logic         prdy, perr;
  int           cur_wait;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign prd  = sel ? prdata3  : prdata0;
  assign prdy = sel ? pready3  : pready0;
  assign perr = sel ? pslverr3 : pslverr0;

  apb_regfile #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h80)) dut0 (
    .pclk(clk), .preset_n(rst_n), .psel(psel & ~sel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .reg_out(reg_out0), .status_in(status0));

  apb_regfile #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h00)) dut3 (
    .pclk(clk), .preset_n(rst_n), .psel(psel & sel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .reg_out(reg_out3), .status_in(status3));

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit w, logic [7:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] exp_rd, bit exp_err);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives setup then access; returns once pready is seen (or bound expires),
  // leaving psel/penable high so the next edge commits a write.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    while (!prdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prd;
    er = perr;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(v.w, v.a, v.d, v.s, rd, er, lat);
    check({tag, "_lat"}, lat, cur_wait);
    check({tag, "_err"}, {31'b0, er}, {31'b0, v.exp_err});
    if (!v.w) check({tag, "_rdata"}, rd, v.exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; cur_wait = 0;
    status0 = '0; status0[7*32 +: 32] = 32'h0000CAFE;
    status3 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pready0",  {31'b0, pready0},  32'h0);
    check("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
    check("rst_prdata0",  prdata0, 32'h0);
    check("rst_pready3",  {31'b0, pready3},  32'h0);
    check("rst_regout0_lo", reg_out0[31:0], 32'h0);
    check("rst_regout3_lo", reg_out3[31:0], 32'h0);
    rst_n = 1'b1;

    // ---------------- table vectors on dut0 (no wait states) ----------------
    for (int i = 0; i < 7; i++) vt.push_back(mk(1'b0, 8'(i), 32'h0, 4'h0, 32'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'd7, 32'h0,        4'hF, 32'h0000CAFE, 1'b0));
    vt.push_back(mk(1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
    vt.push_back(mk(1'b1, 8'd3, 32'h11223344, 4'h5, 32'h0,        1'b0));
    vt.push_back(mk(1'b0, 8'd3, 32'h0,        4'h0, 32'hDE22BE44, 1'b0));
    vt.push_back(mk(1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0));
    vt.push_back(mk(1'b0, 8'd5, 32'h0,        4'h0, 32'h0,        1'b0));
    vt.push_back(mk(1'b1, 8'd7, 32'h12345678, 4'hF, 32'h0,        1'b1));
    vt.push_back(mk(1'b0, 8'd7, 32'h0,        4'h0, 32'h0000CAFE, 1'b0));
    vt.push_back(mk(1'b0, 8'd8, 32'h0,        4'h0, 32'h0,        1'b1));
    vt.push_back(mk(1'b1, 8'hFF, 32'hFFFFFFFF, 4'hF, 32'h0,       1'b1));
    vt.push_back(mk(1'b0, 8'd3, 32'h0,        4'h0, 32'hDE22BE44, 1'b0));
    vt.push_back(mk(1'b0, 8'd0, 32'h0,        4'h0, 32'h0,        1'b0));

    sel = 1'b0; cur_wait = 0;
    foreach (vt[i]) run_vec($sformatf("vec%0d", i), vt[i]);
    idle();
    check("regout0_slot3", reg_out0[3*32 +: 32], 32'hDE22BE44);
    check("regout0_slot5", reg_out0[5*32 +: 32], 32'h0);
    check("regout0_slot7_ro", reg_out0[7*32 +: 32], 32'h0);
    check("regout0_slot0", reg_out0[0 +: 32], 32'h0);

    // ---------------- dut3: wait-state write timing ----------------
    sel = 1'b1; cur_wait = 3;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd0; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w3_wait%0d_pready", k), {31'b0, pready3}, 32'h0);
      check($sformatf("w3_wait%0d_regout", k), reg_out3[0 +: 32], 32'h0);
      @(posedge clk); #1;
    end
    check("w3_resp_pready",  {31'b0, pready3},  32'h1);
    check("w3_resp_pslverr", {31'b0, pslverr3}, 32'h0);
    check("w3_resp_regout",  reg_out3[0 +: 32], 32'h0);
    idle();
    check("w3_after_regout", reg_out3[0 +: 32], 32'hA5A5A5A5);

    // psel dropped in wait cycle 2: no write, no pready
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_wait1_pready", {31'b0, pready3}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (pready3) seen = 1'b1;
    end
    check("abort_no_pready", {31'b0, seen}, 32'h0);
    check("abort_no_write", reg_out3[2*32 +: 32], 32'h0);
    xfer(1'b0, 8'd0, 32'h0, 4'h0, rd, er, lat);
    check("abort_next_lat", lat, 3);
    check("abort_next_rdata", rd, 32'hA5A5A5A5);
    idle();

    // ---------------- reset during WAIT of a write to reg 1 ----------------
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw_pready",  {31'b0, pready3},  32'h0);
    check("rstw_pslverr", {31'b0, pslverr3}, 32'h0);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (pready3) seen = 1'b1;
    end
    check("rstw_no_pready", {31'b0, seen}, 32'h0);
    check("rstw_reg1", reg_out3[1*32 +: 32], 32'h0);
    check("rstw_reg0_cleared", reg_out3[0 +: 32], 32'h0);
    check("rstw_dut0_reg3_cleared", reg_out0[3*32 +: 32], 32'h0);
    xfer(1'b1, 8'd1, 32'h0BADF00D, 4'hF, rd, er, lat);
    check("rstw_wr_lat", lat, 3);
    check("rstw_wr_err", {31'b0, er}, 32'h0);
    xfer(1'b0, 8'd1, 32'h0, 4'h0, rd, er, lat);
    check("rstw_rd_lat", lat, 3);
    check("rstw_rd_data", rd, 32'h0BADF00D);
    idle();
    check("rstw_regout1", reg_out3[1*32 +: 32], 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
